// File: rtl/fft_sys_pkg.sv
// Shared FFT subsystem definitions: sequencer state encodings and default frame/watchdog limits.
package fft_sys_pkg;

  localparam int STATE_W            = 3;
  localparam int FRAME_DIV_DEF      = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16777215;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    COMPUTE = 3'd3,
    SWAP    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Sequencer handshake bundle: control inputs, sampler/FFT strobes, bank selects and status.
interface fft_frame_sequencer_if;
  import fft_sys_pkg::*;

  logic               enable;
  logic               vsync;
  logic               smpl_done;
  logic               fft_done;
  logic               smpl_trig;
  logic               fft_start;
  logic               disp_bank;
  logic               fft_bank;
  logic [15:0]        frame_cnt;
  logic               busy;
  logic               err;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    output enable, vsync, smpl_done, fft_done,
    input  smpl_trig, fft_start, disp_bank, fft_bank, frame_cnt, busy, err, state_dbg
  );

  modport slave (
    input  enable, vsync, smpl_done, fft_done,
    output smpl_trig, fft_start, disp_bank, fft_bank, frame_cnt, busy, err, state_dbg
  );
endinterface

// File: rtl/fft_frame_sequencer_vsync_divider.sv
// Counts vsync pulses while armed; tc flags the vsync that completes FRAME_DIV frames.
module vsync_divider
  import fft_sys_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic vsync,
  output logic tc
);

  if (FRAME_DIV < 1 || FRAME_DIV > 255) begin : g_bad_frame_div
    $error("vsync_divider: FRAME_DIV must be 1..255");
  end

  localparam logic [7:0] LAST = 8'(FRAME_DIV - 1);

  logic [7:0] cnt;

  assign tc = vsync && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (vsync) begin
      cnt <= tc ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: vsync-divided capture -> FFT -> bank swap on vsync.
// Optional watchdog on CAPTURE+COMPUTE enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_frame_sequencer
  import fft_sys_pkg::*;
#(
  parameter int FRAME_DIV      = FRAME_DIV_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                  clk,
  input logic                  rst,
  fft_frame_sequencer_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16777215) begin : g_bad_timeout
    $error("fft_frame_sequencer: TIMEOUT_CYCLES must be 1..16777215");
  end

  seq_state_t  state, state_d;
  logic        smpl_trig, fft_start, disp_bank, fft_bank, busy, err;
  logic [15:0] frame_cnt;
  logic        smpl_trig_d, fft_start_d, swap_d, timeout_d;
  logic        vs_tc;

  // Divider only counts while armed, so the swap vsync and IDLE vsyncs never count.
  vsync_divider #(.FRAME_DIV(FRAME_DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .clear (state != ARM),
    .vsync (bus.vsync && bus.enable),
    .tc    (vs_tc)
  );

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] wd_cnt;
  logic        in_frame;

  assign in_frame  = (state == CAPTURE) || (state == COMPUTE);
  assign timeout_d = in_frame && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (in_frame) begin
      wd_cnt <= wd_cnt + 24'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign timeout_d = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    smpl_trig_d = 1'b0;
    fft_start_d = 1'b0;
    swap_d      = 1'b0;
    case (state)
      IDLE:    if (bus.enable) state_d = ARM;
      ARM: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (vs_tc) begin
          state_d     = CAPTURE;
          smpl_trig_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (bus.smpl_done) begin
          state_d     = COMPUTE;
          fft_start_d = 1'b1;
        end
      end
      COMPUTE: if (bus.fft_done) state_d = SWAP;
      SWAP: begin
        if (bus.vsync) begin
          swap_d  = 1'b1;
          state_d = bus.enable ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A timed-out frame is abandoned: no FFT start and no swap.
    if (timeout_d) begin
      state_d     = IDLE;
      fft_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      smpl_trig <= 1'b0;
      fft_start <= 1'b0;
      disp_bank <= 1'b0;
      fft_bank  <= 1'b1;
      frame_cnt <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      smpl_trig <= smpl_trig_d;
      fft_start <= fft_start_d;
      busy      <= (state_d != IDLE);
      err       <= err | timeout_d;
      if (swap_d) begin
        disp_bank <= ~disp_bank;
        fft_bank  <= ~fft_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign bus.smpl_trig = smpl_trig;
  assign bus.fft_start = fft_start;
  assign bus.disp_bank = disp_bank;
  assign bus.fft_bank  = fft_bank;
  assign bus.frame_cnt = frame_cnt;
  assign bus.busy      = busy;
  assign bus.err       = err;
  assign bus.state_dbg = state;

endmodule
